// File: rtl/axis_checker_pkg.sv
// Shared types and constants for the counter-pattern AXI-Stream checker.
// FSM encoding, err_flags bit positions and LFSR throttle constants.
package axis_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam int ERR_W    = 3;
  localparam int ERR_DATA = 0;
  localparam int ERR_KEEP = 1;
  localparam int ERR_LAST = 2;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting right: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/axis_data_checker_cntr_lfsr_16.sv
// 16-bit Fibonacci LFSR used to throttle tready; state is registered, advances when step_i is high.
// Latency: one cycle per step; no backpressure of its own.
module lfsr_16
  import axis_checker_pkg::*;
(
  input  logic        clk_i,
  input  logic        s_rst_i,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/axis_data_checker_cntr.sv
// AXIS sink checking a counter-pattern stream; status/error outputs valid one cycle after the beat.
// Registered tready follows enable_i (AND LFSR bit 0 when AXIS_DATA_CHECKER_THROTTLE_EN is defined).
module axis_data_checker_cntr
  import axis_checker_pkg::*;
#(
  parameter int                             AXIS_DATA_WIDTH = 32,
  parameter logic [AXIS_DATA_WIDTH/8-1:0]   AXIS_TKEEP      = '1,
  parameter int                             PACK_SIZE       = 1024,
  parameter int                             PACK_NUMBER     = 1024
)(
  input  logic                          clk_i,
  input  logic                          s_rst_i,
  input  logic                          enable_i,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata_i,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_i,
  input  logic                          s_axis_tvalid_i,
  input  logic                          s_axis_tlast_i,
  output logic                          s_axis_tready_o,
  output logic [31:0]                   pack_cnt_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [ERR_W-1:0]              err_flags_o,
  output logic [$clog2(PACK_SIZE)-1:0]  err_beat_o,
  output logic [AXIS_DATA_WIDTH-1:0]    err_data_o
);

  localparam int          BEAT_W      = $clog2(PACK_SIZE);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(PACK_SIZE - 1);
  localparam logic [31:0] PACK_NUM_M1 = 32'(PACK_NUMBER - 1);

  state_e                     state_q,     state_d;
  logic                       tready_q,    tready_d;
  logic [BEAT_W-1:0]          beat_q,      beat_d;
  logic [31:0]                pack_cnt_q,  pack_cnt_d;
  logic                       done_q,      done_d;
  logic                       error_q,     error_d;
  logic [ERR_W-1:0]           err_flags_q, err_flags_d;
  logic [BEAT_W-1:0]          err_beat_q,  err_beat_d;
  logic [AXIS_DATA_WIDTH-1:0] err_data_q,  err_data_d;

  logic                       throttle_ok;
  logic                       beat_acc;
  logic                       last_exp;
  logic [AXIS_DATA_WIDTH-1:0] exp_data;
  logic [ERR_W-1:0]           mism;

`ifdef AXIS_DATA_CHECKER_THROTTLE_EN
  logic [15:0] lfsr_state;

  lfsr_16 u_lfsr (
    .clk_i   (clk_i),
    .s_rst_i (s_rst_i),
    .step_i  (state_q == RUN),
    .state_o (lfsr_state)
  );

  assign throttle_ok = lfsr_state[0];
`else
  assign throttle_ok = 1'b1;
`endif

  assign beat_acc = s_axis_tvalid_i & tready_q;
  assign last_exp = (beat_q == LAST_BEAT);
  assign exp_data = AXIS_DATA_WIDTH'(beat_q);

  always_comb begin
    mism           = '0;
    mism[ERR_DATA] = (s_axis_tdata_i != exp_data);
    mism[ERR_KEEP] = (s_axis_tkeep_i != AXIS_TKEEP);
    mism[ERR_LAST] = (s_axis_tlast_i != last_exp);
  end

  always_comb begin
    state_d     = state_q;
    tready_d    = tready_q;
    beat_d      = beat_q;
    pack_cnt_d  = pack_cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    err_flags_d = err_flags_q;
    err_beat_d  = err_beat_q;
    err_data_d  = err_data_q;

    case (state_q)
      IDLE: begin
        tready_d = 1'b0;
        if (enable_i) begin
          state_d = RUN;
        end
      end

      RUN: begin
        tready_d = enable_i & throttle_ok;
        if (beat_acc) begin
          if (|mism) begin
            // First failure wins; diagnostics are frozen from here on.
            state_d     = FAULT;
            tready_d    = 1'b1;
            error_d     = 1'b1;
            err_flags_d = mism;
            err_beat_d  = beat_q;
            err_data_d  = s_axis_tdata_i;
          end else if (last_exp) begin
            beat_d     = '0;
            pack_cnt_d = (pack_cnt_q == '1) ? pack_cnt_q : pack_cnt_q + 32'd1;
            if (pack_cnt_q == PACK_NUM_M1) begin
              state_d  = DONE;
              done_d   = 1'b1;
              tready_d = 1'b0;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      DONE: begin
        tready_d = 1'b0;
        done_d   = 1'b1;
      end

      FAULT: begin
        // Keep draining the source so upstream never stalls on a dead sink.
        tready_d = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        tready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      beat_q      <= '0;
      pack_cnt_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_flags_q <= '0;
      err_beat_q  <= '0;
      err_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      beat_q      <= beat_d;
      pack_cnt_q  <= pack_cnt_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_flags_q <= err_flags_d;
      err_beat_q  <= err_beat_d;
      err_data_q  <= err_data_d;
    end
  end

  assign s_axis_tready_o = tready_q;
  assign pack_cnt_o      = pack_cnt_q;
  assign done_o          = done_q;
  assign error_o         = error_q;
  assign err_flags_o     = err_flags_q;
  assign err_beat_o      = err_beat_q;
  assign err_data_o      = err_data_q;

endmodule

// File: doc/axis_data_checker_cntr.md
Name: axis_data_checker_cntr

Overview:
AXI-Stream sink that consumes the counter-pattern stream produced by the team's counter-driven AXIS data generator and checks it beat by beat.
- Checks data, tkeep and tlast against the expected sequence.
- Generates tready.
- Counts good packets.
- Freezes diagnostic information on the first mismatch.
- Sits at the far end of a loopback or DMA path in hardware tests; doubles as a self-checking monitor in benches.

Parameters:
- AXIS_DATA_WIDTH, 32: tdata width, multiple of 8.
- AXIS_TKEEP, all ones (AXIS_DATA_WIDTH/8 bits): required tkeep on every beat.
- PACK_SIZE, 1024: beats per packet, must be at least 2.
- PACK_NUMBER, 1024: packets to accept before done_o.

Ports:
- clk_i  in  1  clock.
- s_rst_i  in  1  synchronous reset, active-high.
- enable_i  in  1  allows acceptance when high.
- s_axis_tdata_i  in  AXIS_DATA_WIDTH  stream data.
- s_axis_tkeep_i  in  AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tvalid_i  in  1  source valid.
- s_axis_tlast_i  in  1  end of packet.
- s_axis_tready_o  out  1  sink ready, registered.
- pack_cnt_o  out  32  packets accepted without error, saturating.
- done_o  out  1  PACK_NUMBER packets accepted.
- error_o  out  1  sticky, any check failed.
- err_flags_o  out  3  {last, keep, data} mismatch flags of the failing beat.
- err_beat_o  out  $clog2(PACK_SIZE)  beat index of the failing beat.
- err_data_o  out  AXIS_DATA_WIDTH  tdata captured on the failing beat.

Behaviour:

Reset:
- s_rst_i high on a clock edge clears all outputs and counters to 0 and puts the FSM in IDLE.
- Applies mid-packet too: the partial packet is discarded and the next accepted beat is checked as beat 0.

Handshake and expected sequence:
- A beat is accepted when s_axis_tvalid_i and s_axis_tready_o are both high at a clock edge.
- Beat index k runs 0..PACK_SIZE-1. Expected tdata = k, zero-extended to AXIS_DATA_WIDTH.
- Expected tkeep = AXIS_TKEEP.
- Expected tlast = 1 exactly when k = PACK_SIZE-1.
- k wraps to 0 after the last beat.

FSM (tready_o is registered, so it reflects the state and enable_i of the previous cycle):
- IDLE: tready_o=0. Go to RUN when enable_i=1.
- RUN: tready_o = enable_i, gated by the throttle when that feature is compiled in.
  - enable_i low: tready_o drops on the next edge. k and the packet count are held.
  - Beat accepted with all checks passing: k increments.
  - On the last beat: k clears and pack_cnt_o increments.
  - When pack_cnt_o reaches PACK_NUMBER: go to DONE.
  - Any check fails on an accepted beat: go to FAULT; the failing beat is not counted.
- DONE: done_o=1, tready_o=0. Stays until reset.
- FAULT:
  - error_o=1.
  - err_flags_o, err_beat_o and err_data_o hold the values captured on the edge that detected the first failure. They are never overwritten.
  - tready_o=1 regardless of enable_i, to drain the source. No further checks are made.
  - Stays until reset.

Latency:
- error_o and the err_* outputs are valid on the cycle after the failing handshake.
- pack_cnt_o updates on the cycle after the tlast handshake.

Boundary cases:
- tvalid while tready_o=0: ignored.
- Simultaneous last beat and PACK_NUMBER reached: pack_cnt_o=PACK_NUMBER and done_o=1 on the same cycle.
- pack_cnt_o saturates at 2^32-1.

Optional Feature:
Macro AXIS_DATA_CHECKER_THROTTLE_EN.
- Defined: a 16-bit Fibonacci LFSR is included, seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1.
  - It advances every cycle in RUN and resets to the seed.
  - In RUN, tready_o = enable_i AND lfsr[0], registered.
  - This exercises source backpressure.
- Undefined: no LFSR; in RUN, tready_o = enable_i, registered.
- DONE and FAULT behaviour is identical in both builds.

Decomposition:
- Package axis_checker_pkg holds:
  - the FSM state typedef (IDLE, RUN, DONE, FAULT);
  - the err_flags bit-position constants (ERR_DATA=0, ERR_KEEP=1, ERR_LAST=2);
  - the LFSR seed and tap constants.
- One natural sub-module: lfsr_16, with clk_i, s_rst_i, step enable and a 16-bit state output. It is instantiated only under the macro.

Test Plan:
1. Reset, then enable, with PACK_SIZE=4 and PACK_NUMBER=2. Source sends 0,1,2,3(last),0,1,2,3(last) with tvalid always high. Required: pack_cnt_o=1 after beat 3, pack_cnt_o=2 and done_o=1 after beat 7, tready_o=0 afterwards, error_o=0.
2. With PACK_SIZE=4, beat 2 carries 32'h5. Required: error_o=1 one cycle later, err_flags_o=3'b001, err_beat_o=2, err_data_o=5, pack_cnt_o=0, tready_o held at 1.
3. tlast asserted on beat 1 of a 4-beat packet. Required: err_flags_o=3'b100, err_beat_o=1. Same for tlast missing on beat 3: err_flags_o=3'b100, err_beat_o=3.
4. tkeep=4'h7 on beat 0 with correct data. Required: err_flags_o=3'b010, err_beat_o=0.
5. Drop enable_i for 10 cycles mid-packet after beat 1, with tvalid held high. Required: tready_o low for those cycles, no acceptance, and the packet resumes at beat 2 without error. Then assert s_rst_i after beat 1 of the next packet. Required: all outputs cleared and the sequence restarts at 0.
6. Build with AXIS_DATA_CHECKER_THROTTLE_EN, run 64 full packets with a randomly stalling source. Required: tready_o toggles, pack_cnt_o=64, error_o=0.
